// File: rtl/glb_token_arbiter.sv
// Arbitrates ifmap/ipsum GLB reads and opsum GLB writes onto a single GLB port, one access per cycle.
// Optional: define GLB_ARB_STARVE_CNT_EN for per-class starvation counters and starve_flag_o.
module glb_token_arbiter #(
    parameter int NUM_CH    = 32,
    parameter int ADDR_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ifmap_read_req_matrix_i,
    input  logic [NUM_CH-1:0]        ipsum_read_req_matrix_i,
    input  logic [NUM_CH-1:0]        opsum_write_req_matrix_i,
    input  logic [NUM_CH*ADDR_W-1:0] ifmap_read_addr_matrix_i,
    input  logic [NUM_CH*ADDR_W-1:0] ipsum_read_addr_matrix_i,
    input  logic [NUM_CH*ADDR_W-1:0] opsum_write_addr_matrix_i,
    input  logic [NUM_CH*4-1:0]      opsum_write_web_matrix_i,
    input  logic                     write_first_i,
    input  logic                     glb_ready_i,
    output logic                     glb_read_o,
    output logic [ADDR_W-1:0]        glb_read_addr_o,
    output logic                     glb_write_o,
    output logic [ADDR_W-1:0]        glb_write_addr_o,
    output logic [3:0]               glb_write_web_o,
    output logic [NUM_CH-1:0]        permit_ifmap_matrix_o,
    output logic [NUM_CH-1:0]        permit_ipsum_matrix_o,
    output logic [NUM_CH-1:0]        permit_opsum_matrix_o,
`ifdef GLB_ARB_STARVE_CNT_EN
    output logic [2:0]               starve_flag_o,
`endif
    output logic                     busy_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [1:0] CLS_IFMAP = 2'd0;
    localparam logic [1:0] CLS_IPSUM = 2'd1;
    localparam logic [1:0] CLS_OPSUM = 2'd2;

    typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] req [3];
    logic [1:0]        cls_q, cls_d, cls_ptr_q, cls_ptr_eff, sel_cls;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  rr_ptr_q [3];
    logic [IDX_W-1:0]  rr_ptr_eff [3];
    logic [IDX_W-1:0]  cand_idx [3];
    logic [2:0]        cand_vld;
    logic [3:0]        burst_q, burst_d;
    logic              sel_vld, issue, hold, load, active;
    logic [NUM_CH-1:0] perm_if_d, perm_ip_d, perm_op_d;
    logic              read_d, write_d;
    logic [ADDR_W-1:0] read_addr_d, write_addr_d;
    logic [3:0]        web_d;
`ifdef GLB_ARB_STARVE_CNT_EN
    logic [7:0]        wait_cnt_q [3];
    logic [2:0]        starve;
`endif

    function automatic logic [1:0] next_cls(input logic [1:0] c);
        return (c == CLS_OPSUM) ? CLS_IFMAP : c + 2'd1;
    endfunction

    function automatic logic [1:0] rot_cls(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= 3) s = s - 3;
        return 2'(s);
    endfunction

    assign req[0] = ifmap_read_req_matrix_i;
    assign req[1] = ipsum_read_req_matrix_i;
    assign req[2] = opsum_write_req_matrix_i;
    assign issue  = (state_q != IDLE) && glb_ready_i;
    assign busy_o = (state_q != IDLE);

    // The access being issued this cycle already counts as "last issued" for re-arbitration.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            rr_ptr_eff[c] = (issue && cls_q == 2'(c)) ? idx_q : rr_ptr_q[c];
        end
        cls_ptr_eff = issue ? next_cls(cls_q) : cls_ptr_q;
    end

    always_comb begin
        int pos;
        pos = 0;
        for (int c = 0; c < 3; c++) begin
            cand_vld[c] = 1'b0;
            cand_idx[c] = rr_ptr_eff[c];
            for (int off = NUM_CH; off >= 1; off--) begin
                pos = int'(rr_ptr_eff[c]) + off;
                if (pos >= NUM_CH) pos = pos - NUM_CH;
                if (req[c][IDX_W'(pos)]) begin
                    cand_vld[c] = 1'b1;
                    cand_idx[c] = IDX_W'(pos);
                end
            end
        end
    end

    always_comb begin
        sel_vld = |cand_vld;
        sel_cls = CLS_IFMAP;
        for (int k = 2; k >= 0; k--) begin
            if (cand_vld[rot_cls(cls_ptr_eff, k)]) sel_cls = rot_cls(cls_ptr_eff, k);
        end
        if (write_first_i && cand_vld[CLS_OPSUM]) sel_cls = CLS_OPSUM;
`ifdef GLB_ARB_STARVE_CNT_EN
        for (int k = 2; k >= 0; k--) begin
            if (starve[rot_cls(cls_ptr_eff, k)] && cand_vld[rot_cls(cls_ptr_eff, k)])
                sel_cls = rot_cls(cls_ptr_eff, k);
        end
`endif
    end

    always_comb begin
        hold = req[cls_q][idx_q] && (burst_q < 4'(BURST_MAX));
`ifdef GLB_ARB_STARVE_CNT_EN
        for (int c = 0; c < 3; c++) begin
            if (cls_q != 2'(c) && starve[c] && cand_vld[c]) hold = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (sel_vld) state_d = GRANT;
            GRANT, STALL: begin
                if (!glb_ready_i)          state_d = STALL;
                else if (hold || sel_vld)  state_d = GRANT;
                else                       state_d = IDLE;
            end
            default:      state_d = IDLE;
        endcase
    end

    // Output registers only reload at arbitration points; a stall keeps them bit-identical.
    always_comb begin
        load    = (state_q == IDLE) || issue;
        cls_d   = cls_q;
        idx_d   = idx_q;
        burst_d = burst_q;
        if (issue && hold) begin
            burst_d = burst_q + 4'd1;
        end else if (load && sel_vld) begin
            cls_d   = sel_cls;
            idx_d   = cand_idx[sel_cls];
            burst_d = 4'd1;
        end
        active       = (state_d != IDLE);
        perm_if_d    = '0;
        perm_ip_d    = '0;
        perm_op_d    = '0;
        read_addr_d  = '0;
        write_addr_d = '0;
        web_d        = '0;
        read_d       = active && (cls_d != CLS_OPSUM);
        write_d      = active && (cls_d == CLS_OPSUM);
        for (int i = 0; i < NUM_CH; i++) begin
            if (active && idx_d == IDX_W'(i)) begin
                case (cls_d)
                    CLS_IFMAP: begin
                        perm_if_d[i] = 1'b1;
                        read_addr_d  = ifmap_read_addr_matrix_i[i*ADDR_W +: ADDR_W];
                    end
                    CLS_IPSUM: begin
                        perm_ip_d[i] = 1'b1;
                        read_addr_d  = ipsum_read_addr_matrix_i[i*ADDR_W +: ADDR_W];
                    end
                    default: begin
                        perm_op_d[i] = 1'b1;
                        write_addr_d = opsum_write_addr_matrix_i[i*ADDR_W +: ADDR_W];
                        web_d        = opsum_write_web_matrix_i[i*4 +: 4];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cls_q                 <= CLS_IFMAP;
            idx_q                 <= '0;
            burst_q               <= '0;
            cls_ptr_q             <= CLS_IFMAP;
            for (int c = 0; c < 3; c++) rr_ptr_q[c] <= LAST_IDX;
            glb_read_o            <= 1'b0;
            glb_read_addr_o       <= '0;
            glb_write_o           <= 1'b0;
            glb_write_addr_o      <= '0;
            glb_write_web_o       <= '0;
            permit_ifmap_matrix_o <= '0;
            permit_ipsum_matrix_o <= '0;
            permit_opsum_matrix_o <= '0;
        end else begin
            cls_q   <= cls_d;
            idx_q   <= idx_d;
            burst_q <= burst_d;
            if (issue) begin
                rr_ptr_q[cls_q] <= idx_q;
                cls_ptr_q       <= next_cls(cls_q);
            end
            if (load) begin
                glb_read_o            <= read_d;
                glb_read_addr_o       <= read_addr_d;
                glb_write_o           <= write_d;
                glb_write_addr_o      <= write_addr_d;
                glb_write_web_o       <= web_d;
                permit_ifmap_matrix_o <= perm_if_d;
                permit_ipsum_matrix_o <= perm_ip_d;
                permit_opsum_matrix_o <= perm_op_d;
            end
        end
    end

`ifdef GLB_ARB_STARVE_CNT_EN
    // A class waits while it has any request and is not the one issuing; saturates at 255.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 3; c++) wait_cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (issue && cls_q == 2'(c))
                    wait_cnt_q[c] <= '0;
                else if ((|req[c]) && wait_cnt_q[c] != 8'hFF)
                    wait_cnt_q[c] <= wait_cnt_q[c] + 8'd1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) starve[c] = (wait_cnt_q[c] == 8'hFF);
    end

    assign starve_flag_o = starve;
`endif

endmodule

// File: tb/tb_glb_token_arbiter.sv
// Testbench for glb_token_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_glb_token_arbiter;

    localparam int NUM_CH    = 32;
    localparam int ADDR_W    = 32;
    localparam int BURST_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [NUM_CH-1:0]        ifmap_req, ipsum_req, opsum_req;
    logic [NUM_CH*ADDR_W-1:0] ifmap_addr, ipsum_addr, opsum_addr;
    logic [NUM_CH*4-1:0]      opsum_web;
    logic                     write_first, glb_ready;
    logic                     glb_read, glb_write, busy;
    logic [ADDR_W-1:0]        glb_read_addr, glb_write_addr;
    logic [3:0]               glb_write_web;
    logic [NUM_CH-1:0]        permit_ifmap, permit_ipsum, permit_opsum;
`ifdef GLB_ARB_STARVE_CNT_EN
    logic [2:0]               starve_flag;
`endif

    glb_token_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .ifmap_read_req_matrix_i  (ifmap_req),
        .ipsum_read_req_matrix_i  (ipsum_req),
        .opsum_write_req_matrix_i (opsum_req),
        .ifmap_read_addr_matrix_i (ifmap_addr),
        .ipsum_read_addr_matrix_i (ipsum_addr),
        .opsum_write_addr_matrix_i(opsum_addr),
        .opsum_write_web_matrix_i (opsum_web),
        .write_first_i            (write_first),
        .glb_ready_i              (glb_ready),
        .glb_read_o               (glb_read),
        .glb_read_addr_o          (glb_read_addr),
        .glb_write_o              (glb_write),
        .glb_write_addr_o         (glb_write_addr),
        .glb_write_web_o          (glb_write_web),
        .permit_ifmap_matrix_o    (permit_ifmap),
        .permit_ipsum_matrix_o    (permit_ipsum),
        .permit_opsum_matrix_o    (permit_opsum),
`ifdef GLB_ARB_STARVE_CNT_EN
        .starve_flag_o            (starve_flag),
`endif
        .busy_o                   (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: which requester (if any) is currently presented, plus the rotation history.
    bit          m_active;
    int          m_cls, m_idx, m_burst, m_next_cls;
    int          m_last [3];
    logic [31:0] m_addr;
    logic [3:0]  m_web;

    function automatic logic [NUM_CH-1:0] class_req(input int c);
        return (c == 0) ? ifmap_req : (c == 1) ? ipsum_req : opsum_req;
    endfunction

    function automatic void m_latch();
        if (m_cls == 0)      m_addr = ifmap_addr[m_idx*ADDR_W +: ADDR_W];
        else if (m_cls == 1) m_addr = ipsum_addr[m_idx*ADDR_W +: ADDR_W];
        else                 m_addr = opsum_addr[m_idx*ADDR_W +: ADDR_W];
        m_web = (m_cls == 2) ? opsum_web[m_idx*4 +: 4] : 4'h0;
    endfunction

    function automatic void m_pick();
        int c;
        logic [NUM_CH-1:0] v;
        c = -1;
        if (write_first && opsum_req != '0) c = 2;
        else begin
            for (int k = 0; k < 3; k++)
                if (c < 0 && class_req((m_next_cls + k) % 3) != '0) c = (m_next_cls + k) % 3;
        end
        if (c < 0) begin
            m_active = 1'b0;
            return;
        end
        v = class_req(c);
        for (int k = NUM_CH; k >= 1; k--)
            if (v[(m_last[c] + k) % NUM_CH]) m_idx = (m_last[c] + k) % NUM_CH;
        m_active = 1'b1;
        m_cls    = c;
        m_burst  = 1;
        m_latch();
    endfunction

    function automatic void model_step();
        logic [NUM_CH-1:0] v;
        if (rst_n) begin
            m_active   = 1'b0;
            m_next_cls = 0;
            for (int c = 0; c < 3; c++) m_last[c] = NUM_CH - 1;
            return;
        end
        if (m_active && !glb_ready) return;
        if (m_active) begin
            m_last[m_cls] = m_idx;
            m_next_cls    = (m_cls + 1) % 3;
            v = class_req(m_cls);
            if (v[m_idx] && m_burst < BURST_MAX) begin
                m_burst++;
                m_latch();
                return;
            end
        end
        m_pick();
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_output();
        logic [NUM_CH-1:0] one;
        logic [NUM_CH-1:0] e [3];
        bit rd, wr;
        one = 1;
        for (int c = 0; c < 3; c++) e[c] = (m_active && m_cls == c) ? (one << m_idx) : '0;
        rd = m_active && m_cls != 2;
        wr = m_active && m_cls == 2;
        check_val("permit_ifmap", permit_ifmap, e[0]);
        check_val("permit_ipsum", permit_ipsum, e[1]);
        check_val("permit_opsum", permit_opsum, e[2]);
        check_val("glb_read", glb_read, rd);
        check_val("glb_read_addr", glb_read_addr, rd ? m_addr : 32'h0);
        check_val("glb_write", glb_write, wr);
        check_val("glb_write_addr", glb_write_addr, wr ? m_addr : 32'h0);
        check_val("glb_write_web", glb_write_web, wr ? m_web : 4'h0);
        check_val("busy", busy, m_active);
        check_val("one_access", ($countones({permit_ifmap, permit_ipsum, permit_opsum}) <= 1)
                  && !(glb_read && glb_write), 1'b1);
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    initial begin
        bit granted, flag_seen;
        rst_n = 1'b1;
        ifmap_req = '0; ipsum_req = '0; opsum_req = '0;
        write_first = 1'b0; glb_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            ifmap_addr[i*ADDR_W +: ADDR_W] = 32'h1000_0000 + i;
            ipsum_addr[i*ADDR_W +: ADDR_W] = 32'h2000_0000 + i;
            opsum_addr[i*ADDR_W +: ADDR_W] = 32'h3000_0000 + i;
            opsum_web[i*4 +: 4]            = 4'(i);
        end

        repeat (2) apply_stimulus();
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_read", glb_read, 1'b0);
        rst_n = 1'b0;

        // Two ifmap requesters alternate in bursts of BURST_MAX.
        ifmap_req = 32'h0000_0021;
        for (int k = 0; k < 16; k++) begin
            apply_stimulus();
            check_val("burst_alternate", permit_ifmap, ((k / 4) % 2 == 0) ? 32'h1 : 32'h20);
        end
        ifmap_req = '0;
        apply_stimulus();
        check_val("idle_after_drain", busy, 1'b0);

        // Write-first keeps opsum[7] on top until it drops.
        write_first = 1'b1;
        ifmap_req   = 32'h8;
        opsum_req   = 32'h80;
        opsum_addr[7*ADDR_W +: ADDR_W] = 32'hABCD_0007;
        opsum_web[7*4 +: 4]            = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus();
            check_val("wf_write", glb_write, 1'b1);
            check_val("wf_addr", glb_write_addr, 32'hABCD_0007);
        end
        opsum_req = '0;
        apply_stimulus();
        check_val("wf_ifmap_after_drop", permit_ifmap, 32'h8);
        ifmap_req = '0;
        apply_stimulus();

        // Stall on ipsum[2]: outputs frozen even when the address input moves.
        write_first = 1'b0;
        glb_ready   = 1'b0;
        ipsum_req   = 32'h4;
        ipsum_addr[2*ADDR_W +: ADDR_W] = 32'h100;
        apply_stimulus();
        ipsum_addr[2*ADDR_W +: ADDR_W] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus();
            check_val("stall_addr", glb_read_addr, 32'h100);
            check_val("stall_busy", busy, 1'b1);
        end
        glb_ready = 1'b1;
        ipsum_req = '0;
        apply_stimulus();
        check_val("stall_released", glb_read, 1'b0);

        // Class rotation ifmap -> ipsum -> opsum, then within-class wrap 31 -> 0.
        rst_n = 1'b1;
        apply_stimulus();
        rst_n = 1'b0;
        ifmap_req = 32'h8000_0000; ipsum_req = 32'h8000_0000; opsum_req = 32'h8000_0000;
        for (int k = 0; k < 13; k++) begin
            apply_stimulus();
            check_val("class_rr", {permit_opsum[31], permit_ipsum[31], permit_ifmap[31]},
                      3'b001 << ((k / 4) % 3));
        end
        ifmap_req = 32'h8000_0001;
        for (int k = 0; k < 12; k++) apply_stimulus();
        check_val("rr_wrap", permit_ifmap, 32'h1);
        ifmap_req = '0; ipsum_req = '0; opsum_req = '0;
        apply_stimulus();
        apply_stimulus();

        // Reset while stalled drops the access; index 0 wins first afterwards.
        glb_ready = 1'b0;
        ifmap_req = 32'h200;
        repeat (2) apply_stimulus();
        rst_n = 1'b1;
        apply_stimulus();
        check_val("rst_stall_permit", permit_ifmap, 32'h0);
        check_val("rst_stall_busy", busy, 1'b0);
        rst_n     = 1'b0;
        glb_ready = 1'b1;
        ifmap_req = 32'h201;
        apply_stimulus();
        check_val("post_reset_first", permit_ifmap, 32'h1);
        ifmap_req = '0;
        repeat (2) apply_stimulus();

`ifdef GLB_ARB_STARVE_CNT_EN
        rst_n = 1'b1;
        apply_stimulus();
        rst_n = 1'b0;
        write_first = 1'b1;
        opsum_req   = 32'h1;
        ifmap_req   = 32'h2;
        granted     = 1'b0;
        flag_seen   = 1'b0;
        for (int k = 0; k < 256 && !granted; k++) begin
            @(posedge clk);
            #1;
            if (starve_flag[0]) flag_seen = 1'b1;
            if (permit_ifmap[1]) granted = 1'b1;
        end
        check_val("starve_grant", granted, 1'b1);
        check_val("starve_flag", flag_seen, 1'b1);
        ifmap_req = '0; opsum_req = '0; write_first = 1'b0;
        rst_n = 1'b1;
        apply_stimulus();
        rst_n = 1'b0;
`endif

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(3) == 0) ifmap_req = $urandom() & $urandom() & $urandom();
            if ($urandom_range(3) == 0) ipsum_req = $urandom() & $urandom() & $urandom();
            if ($urandom_range(3) == 0) opsum_req = $urandom() & $urandom() & $urandom();
            if ($urandom_range(15) == 0) begin
                ifmap_req = '0; ipsum_req = '0; opsum_req = '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                ifmap_addr[i*ADDR_W +: ADDR_W] = $urandom();
                ipsum_addr[i*ADDR_W +: ADDR_W] = $urandom();
                opsum_addr[i*ADDR_W +: ADDR_W] = $urandom();
                opsum_web[i*4 +: 4]            = 4'($urandom_range(15));
            end
            glb_ready = ($urandom_range(3) != 0);
`ifndef GLB_ARB_STARVE_CNT_EN
            if ($urandom_range(15) == 0) write_first = ~write_first;
`endif
            rst_n = ($urandom_range(127) == 0);
            apply_stimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_token_arbiter.md
GLB_TOKEN_ARBITER -- requirements
Module: glb_token_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 32: requesters per class (ifmap, ipsum, opsum), range 1..32.
REQ-002 SHALL have parameter ADDR_W, default 32: GLB address width.
REQ-003 SHALL have parameter BURST_MAX, default 4: maximum consecutive grants to one requester, range 1..15.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-high reset, asserted when 1.
REQ-006 SHALL have port ifmap_read_req_matrix_i, input, NUM_CH: ifmap GLB read requests.
REQ-007 SHALL have port ipsum_read_req_matrix_i, input, NUM_CH: ipsum/bias GLB read requests.
REQ-008 SHALL have port opsum_write_req_matrix_i, input, NUM_CH: opsum GLB write requests.
REQ-009 SHALL have ports ifmap_read_addr_matrix_i, ipsum_read_addr_matrix_i and opsum_write_addr_matrix_i, input, NUM_CH x ADDR_W: per-requester addresses.
REQ-010 SHALL have port opsum_write_web_matrix_i, input, NUM_CH x 4: per-requester byte write enables.
REQ-011 SHALL have port write_first_i, input, 1: 1 selects the opsum class at fixed top priority; 0 selects round-robin between classes.
REQ-012 SHALL have port glb_ready_i, input, 1: GLB accepts the presented access this cycle.
REQ-013 SHALL have ports glb_read_o (1), glb_read_addr_o (ADDR_W), glb_write_o (1), glb_write_addr_o (ADDR_W) and glb_write_web_o (4), all outputs, all registered.
REQ-014 SHALL have ports permit_ifmap_matrix_o, permit_ipsum_matrix_o and permit_opsum_matrix_o, outputs, NUM_CH each: one-hot grant, registered.
REQ-015 SHALL have port busy_o, output, 1: the state is not IDLE.

Function
REQ-016 SHALL present at most one access per cycle; across all three permit vectors at most one bit SHALL be 1, and glb_read_o and glb_write_o SHALL never be 1 together.
REQ-017 SHALL implement states IDLE, GRANT and STALL.
REQ-018 SHALL transition IDLE->GRANT when any request is 1. Outputs SHALL appear one cycle after the request is sampled (latency 1).
REQ-019 SHALL treat an access as issued in the cycle where permit is 1 and glb_ready_i is 1.
REQ-020 SHALL transition GRANT->STALL when permit is 1 and glb_ready_i is 0. In STALL, all outputs SHALL stay bit-identical. STALL->GRANT SHALL occur when glb_ready_i is 1.
REQ-021 SHALL, on each issue, keep the same requester when its request is still 1 and its burst count is below BURST_MAX; otherwise it SHALL re-arbitrate.
REQ-022 SHALL, within a class, arbitrate round-robin, starting from the index one above the last issued index of that class and wrapping from NUM_CH-1 to 0.
REQ-023 SHALL, when write_first_i is 0, choose the class round-robin in the order ifmap -> ipsum -> opsum, skipping classes with no request.
REQ-024 SHALL return to IDLE after an issue when no request remains, clearing all outputs in that transition.
REQ-025 SHALL keep a request dropped while it is granted held through STALL (requesters must hold their request), and SHALL re-arbitrate it on issue.
REQ-026 SHALL sample write_first_i only at arbitration points; a change mid-burst SHALL take effect at the next re-arbitration.
REQ-027 SHALL count bursts in a 4-bit counter that resets to 1 on every new grant.

Reset
REQ-028 SHALL, when rst_n is 1 at a clock edge, set state to IDLE, all outputs to 0, all round-robin pointers to NUM_CH-1 (so index 0 wins first) and the class pointer to ifmap.
REQ-029 SHALL, on reset mid-STALL, drop the pending access, so the GLB sees glb_read_o and glb_write_o at 0 on the next cycle.

Configuration
REQ-030 SHALL, when GLB_ARB_STARVE_CNT_EN is defined, keep an 8-bit wait counter per class. A class whose counter reaches 255 SHALL become top priority at the next arbitration, overriding both write_first_i and the burst hold. The counter SHALL reset on that class's issue. Port starve_flag_o, output, 3, SHALL indicate saturated classes.
REQ-031 SHALL, when GLB_ARB_STARVE_CNT_EN is undefined, omit the counters and starve_flag_o, with arbitration exactly as in REQ-021..REQ-023.

Verification
REQ-032 SHALL verify: reset, then ifmap req bits 0 and 5 held, glb_ready_i=1, BURST_MAX=4 -> permit bit 0 for 4 cycles, then bit 5 for 4 cycles, alternating.
REQ-033 SHALL verify: write_first_i=1, ifmap[3] and opsum[7] requesting -> glb_write_o=1 with opsum[7] addr/web first; ifmap[3] is granted only after opsum[7] drops.
REQ-034 SHALL verify: grant to ipsum[2] with addr 0x100, glb_ready_i=0 for 5 cycles -> outputs stable for 5 cycles, issue on the 6th, busy_o=1 throughout.
REQ-035 SHALL verify: write_first_i=0, all three classes requesting bit 31 -> grant order ifmap, ipsum, opsum, ifmap; the round-robin wraps 31->0 when bit 0 is added.
REQ-036 SHALL verify: rst_n=1 asserted during STALL -> next cycle all permits 0, state IDLE, and the first post-reset grant goes to index 0.
REQ-037 SHALL verify, with GLB_ARB_STARVE_CNT_EN defined and write_first_i=1: continuous opsum requests plus ifmap[1] -> ifmap[1] granted within 256 cycles and starve_flag_o[0] pulses.
